adjust_repeater: RTL and testbench
==================================

# adjust_repeater

Converts the debounced, registered `adjust` level from the adjust-button front end into single-cycle increment strobes for the time-setting counters. One strobe on press. If the button is held, strobes auto-repeat after a hold delay. The block sits between the button conditioning stage and the hour/minute adjust logic, timed by the clock's slow `tick` enable.

## Interface
Parameters:
- `HOLD_TICKS`, 500: ticks of continuous hold before auto-repeat starts (≥2).
- `REPEAT_TICKS`, 100: ticks between auto-repeat strobes (≥2).
- `CNT_W`, 10: tick counter width; must hold max(HOLD_TICKS, REPEAT_TICKS)−1.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `clear_n`  in  1  reset, asynchronous assert, active-low.
- `tick`  in  1  one-cycle timebase strobe (e.g. 1 kHz); only ticks advance the counter.
- `adjust_level`  in  1  debounced adjust level, already synchronous to `clk`.
- `adjust_pulse`  out  1  one-cycle increment strobe.
- `repeating`  out  1  high while in auto-repeat mode.

## Operation
- FSM states: IDLE, HOLD, REPEAT.
- IDLE:
  - Counter = 0.
  - On `adjust_level`=1: go to HOLD and register `adjust_pulse`=1 for the next cycle (press strobe).
- HOLD:
  - Each cycle with `tick`=1, the counter increments.
  - On `tick` with counter = HOLD_TICKS−1: counter←0, go to REPEAT, emit strobe.
- REPEAT:
  - Each `tick` increments the counter.
  - On `tick` with counter = interval−1: counter←0, emit strobe, stay in REPEAT.
- Release: `adjust_level`=0 in any state forces IDLE next cycle, counter←0, no strobe. Release takes priority over a coincident tick-terminal event.
- Re-press: if `adjust_level` rises in the cycle immediately after returning to IDLE, this is a new press and produces a strobe.
- Counter saturation: the counter never wraps. Terminal compare is equality. Widths are sized by `CNT_W`.
- `repeating` = (state == REPEAT), registered.

## Timing
- Reset values: state IDLE, counter 0, `adjust_pulse`=0, `repeating`=0. Reset is asynchronous. Deasserting `clear_n` mid-hold yields IDLE with no strobe.
- Press latency: `adjust_level` sampled 1 at edge N gives `adjust_pulse`=1 during cycle N+1, exactly one cycle wide.
- First repeat strobe: one cycle after the HOLD_TICKS-th tick following the press edge.
- Repeat period: REPEAT_TICKS ticks. Each strobe appears one cycle after its terminal tick.
- `repeating` rises in the same cycle as the first repeat strobe. It falls one cycle after `adjust_level` is sampled 0.
- `tick` held high continuously is legal and means every cycle counts.

## Configuration
- `ADJUST_ACCEL_EN` defined:
  - The block counts repeat strobes in REPEAT, using a 3-bit counter saturating at 7.
  - After the 8th repeat strobe, the interval becomes REPEAT_TICKS/2 (floor, min 1) until release.
  - The strobe count clears on entry to IDLE.
- `ADJUST_ACCEL_EN` undefined: interval is always REPEAT_TICKS. No strobe counter is present.

## Structure
- Shared package `adjust_pkg`:
  - state enum `adjust_state_t` (IDLE/HOLD/REPEAT);
  - constant `ADJUST_ACCEL_AFTER`=8.
- Single module: one FSM plus one tick counter. No sub-module. The counter is simple enough to stay inline.

## Test plan
All scenarios use HOLD_TICKS=4, REPEAT_TICKS=2, `tick`=1 every cycle unless stated.
- Reset: hold `clear_n`=0 with `adjust_level`=1 → `adjust_pulse`=0, `repeating`=0 throughout. After release, the first strobe comes one cycle later.
- Short press: `adjust_level`=1 for 3 cycles → exactly one strobe (cycle after first high sample). `repeating` never asserts.
- Long hold: `adjust_level`=1 for 20 cycles:
  - strobe at press+1;
  - next strobe 4 ticks later;
  - then every 2 cycles;
  - `repeating` high from the first repeat strobe.
- Release on terminal tick: drop `adjust_level` in the cycle the HOLD counter reaches 3 → no strobe, state IDLE.
- Sparse tick: `tick` every 5th cycle, hold 40 cycles → repeat strobes 10 cycles apart, each one cycle after a tick.
- `ADJUST_ACCEL_EN`: REPEAT_TICKS=4, hold long → after 8 repeat strobes the spacing drops from 4 to 2 cycles. Release then re-press → spacing is back to 4.

Source files
------------

// File: rtl/adjust_pkg.sv
// rtl/adjust_pkg.sv - shared state encoding and constants for the adjust repeater
package adjust_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } adjust_state_t;

    localparam int ADJUST_ACCEL_AFTER = 8;

endpackage

// File: rtl/adjust_repeater.sv
// rtl/adjust_repeater.sv - press strobe plus tick-timed auto-repeat for the adjust button
// ADJUST_ACCEL_EN: after ADJUST_ACCEL_AFTER repeat strobes the repeat interval halves until release.
module adjust_repeater
    import adjust_pkg::*;
#(
    parameter int HOLD_TICKS   = 500,
    parameter int REPEAT_TICKS = 100,
    parameter int CNT_W        = 10
) (
    input  logic clk,
    input  logic clear_n,
    input  logic tick,
    input  logic adjust_level,
    output logic adjust_pulse,
    output logic repeating
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);

    adjust_state_t    state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc_d;
    logic [CNT_W-1:0] rep_last_d;
    logic             adjust_pulse_q;
    logic             repeating_q;

    assign cnt_inc_d = cnt_q + CNT_W'(1);

`ifdef ADJUST_ACCEL_EN
    localparam int               FAST_TICKS = (REPEAT_TICKS / 2 < 1) ? 1 : REPEAT_TICKS / 2;
    localparam logic [CNT_W-1:0] FAST_LAST  = CNT_W'(FAST_TICKS - 1);

    // Counts strobes issued inside REPEAT; together with the entry strobe,
    // reaching 7 means ADJUST_ACCEL_AFTER repeat strobes have gone out.
    logic [2:0] strobe_cnt_q;

    assign rep_last_d = (strobe_cnt_q == 3'(ADJUST_ACCEL_AFTER - 1)) ? FAST_LAST : REP_LAST;
`else
    assign rep_last_d = REP_LAST;
`endif

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            adjust_pulse_q <= 1'b0;
            repeating_q    <= 1'b0;
`ifdef ADJUST_ACCEL_EN
            strobe_cnt_q   <= 3'd0;
`endif
        end else begin
            adjust_pulse_q <= 1'b0;
            // Release wins over any terminal tick landing in the same cycle.
            if (!adjust_level) begin
                state_q     <= IDLE;
                cnt_q       <= '0;
                repeating_q <= 1'b0;
`ifdef ADJUST_ACCEL_EN
                strobe_cnt_q <= 3'd0;
`endif
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q        <= HOLD;
                        cnt_q          <= '0;
                        adjust_pulse_q <= 1'b1;
                    end
                    HOLD: begin
                        if (tick) begin
                            if (cnt_q == HOLD_LAST) begin
                                cnt_q          <= '0;
                                state_q        <= REPEAT;
                                adjust_pulse_q <= 1'b1;
                                repeating_q    <= 1'b1;
                            end else begin
                                cnt_q <= cnt_inc_d;
                            end
                        end
                    end
                    REPEAT: begin
                        if (tick) begin
                            if (cnt_q == rep_last_d) begin
                                cnt_q          <= '0;
                                adjust_pulse_q <= 1'b1;
`ifdef ADJUST_ACCEL_EN
                                if (strobe_cnt_q != 3'd7) begin
                                    strobe_cnt_q <= strobe_cnt_q + 3'd1;
                                end
`endif
                            end else begin
                                cnt_q <= cnt_inc_d;
                            end
                        end
                    end
                    default: begin
                        state_q     <= IDLE;
                        cnt_q       <= '0;
                        repeating_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign adjust_pulse = adjust_pulse_q;
    assign repeating    = repeating_q;

endmodule

// File: tb/tb_adjust_repeater.sv
// tb/tb_adjust_repeater.sv - directed self-checking bench for adjust_repeater (HOLD_TICKS=4)
module tb_adjust_repeater;

    localparam int HOLD_T = 4;
`ifdef ADJUST_ACCEL_EN
    localparam int REP_T = 4;
`else
    localparam int REP_T = 2;
`endif

    logic clk = 1'b0;
    logic clear_n;
    logic tick;
    logic adjust_level;
    logic adjust_pulse;
    logic repeating;

    int n_assert = 0;
    int n_fail   = 0;

    adjust_repeater #(
        .HOLD_TICKS  (HOLD_T),
        .REPEAT_TICKS(REP_T),
        .CNT_W       (4)
    ) dut (
        .clk         (clk),
        .clear_n     (clear_n),
        .tick        (tick),
        .adjust_level(adjust_level),
        .adjust_pulse(adjust_pulse),
        .repeating   (repeating)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Apply inputs for the next rising edge, then check outputs 1ns after it.
    task automatic step(input logic lvl, input logic tk, input logic ep, input logic er, input string tag);
        adjust_level = lvl;
        tick         = tk;
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, adjust_pulse, ep);
        chk({tag, "_rep"}, repeating, er);
    endtask

    initial begin
        clear_n      = 1'b0;
        adjust_level = 1'b1;
        tick         = 1'b1;
        #1;
        chk("reset_pulse", adjust_pulse, 1'b0);
        chk("reset_rep", repeating, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 1'b0, $sformatf("in_reset%0d", k));
        clear_n = 1'b1;

        // Long hold: press strobe, first repeat 4 ticks later, then every 2 (or 4 with accel).
`ifndef ADJUST_ACCEL_EN
        for (int k = 1; k <= 20; k++)
            step(1'b1, 1'b1, (k == 1) || (k >= 5 && k % 2 == 1), k >= 5, $sformatf("lh%0d", k));
        step(1'b0, 1'b1, 1'b0, 1'b0, "lh_release_on_terminal");
        step(1'b0, 1'b1, 1'b0, 1'b0, "lh_idle");
`endif

        // Short press
        step(1'b1, 1'b1, 1'b1, 1'b0, "sp1");
        step(1'b1, 1'b1, 1'b0, 1'b0, "sp2");
        step(1'b1, 1'b1, 1'b0, 1'b0, "sp3");
        step(1'b0, 1'b1, 1'b0, 1'b0, "sp_rel1");
        step(1'b0, 1'b1, 1'b0, 1'b0, "sp_rel2");

        // Release exactly when the HOLD counter is at its terminal value, then re-press at once
        step(1'b1, 1'b1, 1'b1, 1'b0, "rt_press");
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 1'b0, $sformatf("rt_hold%0d", k));
        step(1'b0, 1'b1, 1'b0, 1'b0, "rt_release");
        step(1'b1, 1'b1, 1'b1, 1'b0, "rt_repress");
        step(1'b1, 1'b1, 1'b0, 1'b0, "rt_repress_hold");
        step(1'b0, 1'b1, 1'b0, 1'b0, "rt_idle");

        // Asynchronous reset while repeating
        step(1'b1, 1'b1, 1'b1, 1'b0, "ar_press");
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 1'b0, $sformatf("ar_hold%0d", k));
        step(1'b1, 1'b1, 1'b1, 1'b1, "ar_first_repeat");
        #2;
        clear_n = 1'b0;
        #1;
        chk("ar_async_pulse", adjust_pulse, 1'b0);
        chk("ar_async_rep", repeating, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, "ar_held");
        clear_n = 1'b1;
        step(1'b1, 1'b1, 1'b1, 1'b0, "ar_new_press");
        step(1'b0, 1'b1, 1'b0, 1'b0, "ar_release");

`ifndef ADJUST_ACCEL_EN
        // Sparse tick: one tick every 5th cycle
        for (int k = 1; k <= 40; k++)
            step(1'b1, (k % 5 == 0), (k == 1) || (k == 20) || (k == 30) || (k == 40), k >= 20,
                 $sformatf("st%0d", k));
        step(1'b0, 1'b0, 1'b0, 1'b0, "st_release");
`else
        // Acceleration: spacing 4 through the 8th repeat strobe, then 2
        for (int k = 1; k <= 40; k++)
            step(1'b1, 1'b1,
                 (k == 1) || (k >= 5 && k <= 33 && (k - 5) % 4 == 0) || (k >= 35 && k % 2 == 1),
                 k >= 5, $sformatf("ac%0d", k));
        step(1'b0, 1'b1, 1'b0, 1'b0, "ac_release");
        for (int k = 1; k <= 9; k++)
            step(1'b1, 1'b1, (k == 1) || (k == 5) || (k == 9), k >= 5, $sformatf("ac_re%0d", k));
        step(1'b0, 1'b1, 1'b0, 1'b0, "ac_release2");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
